mod_reduce_pipe: RTL and testbench
==================================

Name: mod_reduce_pipe

Overview:
- Streaming, parametrised successor to the single-shot start/done modular reducer.
- Computes in_data mod Q by Barrett reduction: 3-stage lockstep pipeline, one result per cycle, valid/ready handshake on both sides.
- Adds a per-item output mode (canonical or centred) and a tag that passes through with the data.
- Sits between the wide multiplier / accumulator outputs and the NTT / coefficient datapath.

Parameters:
- Q, 8380417, modulus; odd, Q > 2.
- QW, 23, output width; must equal ceil(log2(Q)).
- IN_W, 48, input width; QW <= IN_W <= 2*QW+2. Input range is [0, 2^IN_W).
- TAG_W, 4, sideband tag width; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input item present
- in_ready  out  1  block accepts the item this cycle
- in_data  in  IN_W  unsigned value to reduce
- in_mode  in  1  0 = canonical result in [0,Q); 1 = centred result in [-(Q-1)/2, (Q-1)/2], QW-bit two's complement
- in_tag  in  TAG_W  opaque sideband, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_data  out  QW  reduced value
- out_tag  out  TAG_W  tag of the item in out_data

Behaviour:
- Constants: MU = floor(2^IN_W / Q), a localparam of width IN_W-QW+2. All arithmetic unsigned except the final centring step.
- S1 (register): p = in_data * MU, full width; in_data, mode, tag and valid carried alongside.
- S2 (register): qe = p >> IN_W; r = x - qe*Q, truncated to QW+2 bits. Guaranteed 0 <= r < 3Q.
- S3 (register): if r >= 2Q, subtract 2Q; else if r >= Q, subtract Q. Then if mode=1 and r > (Q-1)/2, out = r - Q (two's complement, QW bits); otherwise out = r.
- Latency: 3 cycles from the accepting edge to out_valid when there is no stall.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge.
  - in_ready = !rst && (!out_valid || out_ready).
  - Whole pipeline advances together when adv = (!out_valid || out_ready).
  - When not advancing, every stage register, including the valid bits, holds its value.
  - Bubbles propagate as valid=0 stages; bubbles are not compressed. Maximum 3 items in flight.
- Output stability: while out_valid && !out_ready, out_data and out_tag must not change.
- Ordering: strict FIFO; out_tag sequence equals in_tag sequence.
- Simultaneous accept and emit at full throughput is legal: 1 item/cycle indefinitely with out_ready held high.
- Reset:
  - All stage valid bits cleared at the first rising edge with rst=1. out_valid=0, out_data=0, out_tag=0.
  - in_ready=0 while rst=1.
  - Reset mid-stream discards all in-flight items; no partial output.
  - Datapath registers other than out_data/out_tag need no reset.
- Boundary values:
  - in_data=0 gives 0.
  - in_data = kQ gives 0 in both modes.
  - in_data = 2^IN_W-1 must reduce correctly; the Barrett error bound of 2 must hold at the maximum.
- Protocol: in_data/in_tag/in_mode with in_valid=0 are ignored; no X propagation into valid bits.

Decomposition:
- Package mod_reduce_pkg:
  - Q_DILITHIUM=8380417 and QW_DILITHIUM=23.
  - MODE_CANON=1'b0 and MODE_CENTRED=1'b1.
  - Constant function barrett_mu(q, in_w), also usable by future lane-parallel variants.
- Sub-module mod_correct (combinational, parameters Q, QW): takes r < 3Q plus mode and produces the final out value. It is instantiated in S3 and reused by the NTT butterfly.

Test Plan:
- Canonical, Q=8380417, IN_W=48, out_ready=1; inputs 1000000, 8380417, 16760834, 16760835 -> out_data 1000000, 0, 0, 1, each exactly 3 cycles after its accept.
- Maximum input 0xFFFFFFFFFFFF, mode 0 -> 196579. Also run 10k random 48-bit inputs in both modes against a reference model using the % operator; zero mismatches allowed.
- Centred mode: 8380416 -> 0x7FFFFF (-1); 4190208 -> 4190208; 4190209 -> 0x401000 (-4190208); 0 -> 0.
- Backpressure:
  - Stream tags 0..7 with in_valid=1; hold out_ready=0 from cycle 2 for 5 cycles.
  - Exactly 3 items are accepted, then in_ready=0. out_data/out_tag stay stable throughout the stall.
  - After release, tags emerge 0..7 in order with none lost or duplicated.
- Throughput and bubbles: 20 back-to-back items with out_ready=1 -> 20 results on 20 consecutive cycles. An in_valid=0 gap of 2 cycles appears as 2 out_valid=0 cycles.
- Reset mid-operation: 2 items in flight; assert rst for 1 cycle. Next cycle out_valid=0, out_data=0, out_tag=0; in_ready=0 during rst and 1 after. Neither discarded item ever appears.

Source files
------------

// File: rtl/mod_reduce_pkg.sv
// Shared constants and helpers for the Barrett modular-reduction datapath.
// Lane-parallel variants are expected to reuse barrett_mu for their own MU constants.
package mod_reduce_pkg;

  localparam int Q_DILITHIUM  = 8380417;
  localparam int QW_DILITHIUM = 23;

  localparam logic MODE_CANON   = 1'b0;
  localparam logic MODE_CENTRED = 1'b1;

  localparam int STAGES = 3;

  // floor(2^in_w / q), computed wide enough for any in_w up to 2*QW+2 of practical moduli
  function automatic logic [127:0] barrett_mu(input int q, input int in_w);
    logic [127:0] num;
    num = 128'd1 << in_w;
    return num / 128'(q);
  endfunction

endpackage

// File: rtl/mod_reduce_pipe_correct.sv
// Final correction of a Barrett remainder r < 3Q into [0,Q) or the centred range.
// Purely combinational so the NTT butterfly can drop it into its own pipeline.
module mod_correct
  import mod_reduce_pkg::*;
#(
  parameter int Q  = Q_DILITHIUM,
  parameter int QW = QW_DILITHIUM
) (
  input  logic [QW+1:0] r,
  input  logic          mode,
  output logic [QW-1:0] out
);

  localparam int RW = QW + 2;
  localparam logic [RW-1:0] Q_R    = RW'(Q);
  localparam logic [RW-1:0] Q2_R   = RW'(2 * Q);
  localparam logic [RW-1:0] HALF_R = RW'((Q - 1) / 2);

  logic [RW-1:0] rc;

  always_comb begin
    rc = r;
    if (r >= Q2_R) begin
      rc = r - Q2_R;
    end else if (r >= Q_R) begin
      rc = r - Q_R;
    end
    out = QW'(rc);
    // upper half maps to a negative value; truncation gives the QW-bit two's complement
    if (mode == MODE_CENTRED && rc > HALF_R) begin
      out = QW'(rc - Q_R);
    end
  end

endmodule

// File: rtl/mod_reduce_pipe.sv
// Streaming Barrett reducer: in_data mod Q in a 3-stage lockstep pipeline,
// one result per cycle, valid/ready on both sides, tag and mode ride alongside.
module mod_reduce_pipe
  import mod_reduce_pkg::*;
#(
  parameter int Q     = Q_DILITHIUM,
  parameter int QW    = QW_DILITHIUM,
  parameter int IN_W  = 48,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int MU_W = IN_W - QW + 2;
  localparam int P_W  = IN_W + MU_W;
  localparam int RW   = QW + 2;
  localparam logic [MU_W-1:0] MU   = MU_W'(barrett_mu(Q, IN_W));
  localparam logic [RW-1:0]   Q_R  = RW'(Q);
  localparam logic [RW-1:0]   Q3_R = RW'(3 * Q);

  typedef struct packed {
    logic             mode;
    logic [TAG_W-1:0] tag;
  } side_t;

  logic                adv;
  logic [STAGES:1]     vld_pipe_d, vld_pipe_q;

  // S1: product and the low bits of x (r only needs x modulo 2^RW)
  logic [RW-1:0]       x1_d, x1_q;
  logic [P_W-1:0]      p1_d, p1_q;
  side_t               side1_d, side1_q;

  // S2: Barrett remainder, bounded by 3Q
  logic [MU_W-1:0]     qe2;
  logic [RW-1:0]       r2_d, r2_q;
  side_t               side2_d, side2_q;

  // S3: registered outputs
  logic [QW-1:0]       corr;
  logic [QW-1:0]       out_data_d, out_data_q;
  logic [TAG_W-1:0]    out_tag_d, out_tag_q;

  assign adv       = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready  = !rst && adv;
  assign qe2       = MU_W'(p1_q >> IN_W);
  assign out_valid = vld_pipe_q[STAGES];
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

  mod_correct #(
    .Q  (Q),
    .QW (QW)
  ) u_corr (
    .r    (r2_q),
    .mode (side2_q.mode),
    .out  (corr)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    x1_d       = x1_q;
    p1_d       = p1_q;
    side1_d    = side1_q;
    r2_d       = r2_q;
    side2_d    = side2_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
      // payload only moves with a valid item so bubbles leave the output quiet
      if (in_valid) begin
        x1_d         = RW'(in_data);
        p1_d         = P_W'(in_data) * P_W'(MU);
        side1_d.mode = in_mode;
        side1_d.tag  = in_tag;
      end
      if (vld_pipe_q[1]) begin
        r2_d    = x1_q - RW'(qe2) * Q_R;
        side2_d = side1_q;
      end
      if (vld_pipe_q[2]) begin
        out_data_d = corr;
        out_tag_d  = side2_q.tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    x1_q    <= x1_d;
    p1_q    <= p1_d;
    side1_q <= side1_d;
    r2_q    <= r2_d;
    side2_q <= side2_d;
  end

  a_barrett_bound: assert property (@(posedge clk) disable iff (rst)
    vld_pipe_q[2] |-> (r2_q < Q3_R));

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data_q) && $stable(out_tag_q)));

endmodule

// File: tb/tb_mod_reduce_pipe.sv
// Scoreboard bench for mod_reduce_pipe: directed vectors push expected results,
// an independent monitor pops and compares whenever an output transfers.
module tb_mod_reduce_pipe;

  localparam int QW    = 23;
  localparam int IN_W  = 48;
  localparam int TAG_W = 4;
  localparam longint unsigned QL = 64'd8380417;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_mode = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [QW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  mod_reduce_pipe #(
    .Q     (8380417),
    .QW    (QW),
    .IN_W  (IN_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [QW-1:0]    data;
    logic [TAG_W-1:0] tag;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;
  bit   ov_hist [0:32767];

  bit            hold = 1'b0;
  logic [QW-1:0] hold_data;
  logic [TAG_W-1:0] hold_tag;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endfunction

  function automatic logic [QW-1:0] ref_mod(input logic [IN_W-1:0] x, input bit m);
    longint unsigned xl, r;
    xl = x;
    r  = xl % QL;
    if (m && r > (QL - 1) / 2) r = r + 64'd8388608 - QL;
    return QW'(r);
  endfunction

  // output monitor
  always @(negedge clk) begin
    exp_t e;
    if (cyc < 32768) ov_hist[cyc] = (out_valid === 1'b1);
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_data);
        check("stall_tag", out_tag, hold_tag);
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out: got tag %0d data %0d, expected no output", out_tag, out_data);
        end else begin
          e = sb_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", out_tag, e.tag);
          if (e.lat) check("latency", cyc - e.acc, 3);
        end
      end
      hold      = (out_valid === 1'b1) && !out_ready;
      hold_data = out_data;
      hold_tag  = out_tag;
    end
  end

  task automatic cyc_drive(input bit v, input logic [IN_W-1:0] d, input bit m,
                           input logic [TAG_W-1:0] t, input logic [QW-1:0] e,
                           input bit push, input bit r, output bit acc);
    exp_t x;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_tag    = t;
    out_ready = r;
    @(negedge clk);
    acc = v && (in_ready === 1'b1);
    if (acc && push) begin
      x.data = e; x.tag = t; x.acc = cyc; x.lat = lat_chk;
      sb_q.push_back(x);
    end
  endtask

  task automatic send(input logic [IN_W-1:0] d, input bit m, input logic [TAG_W-1:0] t,
                      input logic [QW-1:0] e, input bit push);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 100) begin
      cyc_drive(1'b1, d, m, t, e, push, 1'b1, acc);
      n++;
    end
    check("send_accept", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cyc_drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion within time limit");
    $fatal(1);
  end

  initial begin
    bit acc;
    int idx, t0, cnt, guard;
    logic [IN_W-1:0] rd;
    bit rm;

    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // canonical and centred directed vectors, back to back
    lat_chk = 1'b1;
    send(48'd1000000,       1'b0, 4'd1,  23'd1000000, 1'b1);
    send(48'd8380417,       1'b0, 4'd2,  23'd0,       1'b1);
    send(48'd16760834,      1'b0, 4'd3,  23'd0,       1'b1);
    send(48'd16760835,      1'b0, 4'd4,  23'd1,       1'b1);
    send(48'hFFFFFFFFFFFF,  1'b0, 4'd5,  23'd196579,  1'b1);
    send(48'd8380416,       1'b1, 4'd6,  23'h7FFFFF,  1'b1);
    send(48'd4190208,       1'b1, 4'd7,  23'd4190208, 1'b1);
    send(48'd4190209,       1'b1, 4'd8,  23'h401000,  1'b1);
    send(48'd0,             1'b1, 4'd9,  23'd0,       1'b1);
    send(48'd41902085,      1'b1, 4'd10, 23'd0,       1'b1);
    send(48'd0,             1'b0, 4'd11, 23'd0,       1'b1);
    send(48'hFFFFFFFFFFFF,  1'b1, 4'd12, 23'd196579,  1'b1);
    idle(5);

    // throughput then a 2-cycle input gap
    t0 = 0;
    for (int i = 0; i < 20; i++) begin
      send(IN_W'(longint'(i) * longint'(QL) + longint'(i)), 1'b0, TAG_W'(i), QW'(i), 1'b1);
      if (i == 0) t0 = cyc;
    end
    idle(2);
    for (int i = 0; i < 3; i++) send(IN_W'(500 + i), 1'b0, TAG_W'(i), QW'(500 + i), 1'b1);
    idle(6);
    for (int j = 0; j < 20; j++) check("tput_valid", ov_hist[t0 + 3 + j], 1);
    check("bubble0", ov_hist[t0 + 23], 0);
    check("bubble1", ov_hist[t0 + 24], 0);
    check("after_gap", ov_hist[t0 + 25], 1);

    // backpressure: out_ready low for cycles 2..6 of the stream
    lat_chk = 1'b0;
    idx = 0;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      cyc_drive(1'b1, IN_W'(1000 * idx + 7), 1'b0, TAG_W'(idx), QW'(1000 * idx + 7),
                1'b1, !(k >= 2 && k < 7), acc);
      if (acc) idx++;
      if (k == 6) begin
        check("bp_accepted", idx, 3);
        check("bp_in_ready", in_ready, 0);
      end
    end
    check("bp_all_sent", idx, 8);
    idle(8);

    // reset with two items in flight; they must never surface
    send(48'd123, 1'b0, 4'hA, 23'd0, 1'b0);
    send(48'd456, 1'b0, 4'hB, 23'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_no_partial", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_data", out_data, 0);
    check("post_rst_out_tag", out_tag, 0);
    check("post_rst_in_ready", in_ready, 1);
    send(48'd789,      1'b0, 4'hC, 23'd789, 1'b1);
    send(48'd25141256, 1'b1, 4'hD, 23'd5,   1'b1);
    idle(8);

    // random values in both modes with random valid/ready against a % model
    cnt = 0;
    guard = 0;
    while (cnt < 10000 && guard < 40000) begin
      rd[47:32] = 16'($urandom);
      rd[31:0]  = $urandom;
      rm = 1'($urandom_range(0, 1));
      cyc_drive($urandom_range(0, 3) != 0, rd, rm, TAG_W'(cnt), ref_mod(rd, rm), 1'b1,
                $urandom_range(0, 3) != 0, acc);
      if (acc) cnt++;
      guard++;
    end
    check("rand_count", cnt, 10000);
    idle(10);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
